// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit: S1 captures the request, S2 computes
// the result and flags. An accumulator holds the last result for chained ops.
module logic_unit_pipe #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             chain,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] ones
);

    typedef struct packed {
        logic [2:0]       op;
        logic             chain;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } req_t;

    req_t             s1_req;
    logic             s1_valid;
    logic             s2_valid;
    logic             s2_load;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] y_eff;
    logic [WIDTH-1:0] f;
    logic [CNT_W-1:0] f_ones;

    assign s2_load   = s1_valid & (!s2_valid | out_ready);
    assign in_ready  = !s1_valid | s2_load;
    assign out_valid = s2_valid;

    always_comb begin
        y_eff = s1_req.chain ? acc : s1_req.y;
        f     = s1_req.x;
        case (s1_req.op)
            3'b000:  f = s1_req.x & y_eff;
            3'b001:  f = s1_req.x | y_eff;
            3'b010:  f = s1_req.x ^ y_eff;
            3'b011:  f = ~s1_req.x;
            3'b100:  f = ~(s1_req.x & y_eff);
            3'b101:  f = ~(s1_req.x | y_eff);
            3'b110:  f = ~(s1_req.x ^ y_eff);
            default: f = s1_req.x;
        endcase
    end

    always_comb begin
        f_ones = '0;
        for (int i = 0; i < WIDTH; i++)
            f_ones = f_ones + CNT_W'(f[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_req   <= '{op: op, chain: chain, x: x, y: y};
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            parity   <= 1'b0;
            ones     <= '0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            result   <= f;
            zero     <= (f == '0);
            parity   <= ^f;
            ones     <= f_ones;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Clear takes priority; the S2 compute above already used the old value.
    always_ff @(posedge clk) begin
        if (!rst_n)       acc <= '0;
        else if (acc_clr) acc <= '0;
        else if (s2_load) acc <= f;
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8) with hand-computed expectations.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, chain, acc_clr, out_valid, out_ready;
    logic       zero, parity;
    logic [2:0] op;
    logic [7:0] x, y, result;
    logic [3:0] ones;

    int checks = 0;
    int errors = 0;

    logic [7:0] all_ops_exp [8] = '{8'h05, 8'hAF, 8'hAA, 8'h5A, 8'hFA, 8'h50, 8'h55, 8'hA5};
    logic [7:0] chain_x     [4] = '{8'h01, 8'h02, 8'h04, 8'hFF};
    logic [2:0] chain_op    [4] = '{3'b001, 3'b001, 3'b001, 3'b010};
    logic [7:0] chain_exp   [4] = '{8'h01, 8'h03, 8'h07, 8'hF8};

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .chain(chain), .x(x), .y(y), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .parity(parity), .ones(ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic c,
                         input logic [7:0] xx, input logic [7:0] yy);
        in_valid = v; op = o; chain = c; x = xx; y = yy;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_result", 64'(result), 0);
        chk("rst_zero", 64'(zero), 0);
        chk("rst_parity", 64'(parity), 0);
        chk("rst_ones", 64'(ones), 0);
        chk("rst_in_ready", 64'(in_ready), 1);

        // single request, latency 2
        drive(1'b1, 3'b000, 1'b0, 8'hF0, 8'h3C);
        tick();
        drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        chk("single_not_yet", 64'(out_valid), 0);
        tick();
        chk("single_valid", 64'(out_valid), 1);
        chk("single_result", 64'(result), 8'h30);
        chk("single_zero", 64'(zero), 0);
        chk("single_parity", 64'(parity), 0);
        chk("single_ones", 64'(ones), 2);
        tick();
        chk("single_drain", 64'(out_valid), 0);

        // all eight ops back-to-back
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b0, 8'hA5, 8'h0F);
            #1;
            chk($sformatf("ops_in_ready_%0d", i), 64'(in_ready), 1);
            tick();
            if (i >= 1) begin
                chk($sformatf("ops_valid_%0d", i - 1), 64'(out_valid), 1);
                chk($sformatf("ops_result_%0d", i - 1), 64'(result), 64'(all_ops_exp[i - 1]));
            end
        end
        drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        tick();
        chk("ops_valid_7", 64'(out_valid), 1);
        chk("ops_result_7", 64'(result), 8'hA5);
        tick();
        chk("ops_drain", 64'(out_valid), 0);

        // backpressure: 3 requests with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 1'b0, 8'hFF, 8'h11);
        #1; chk("bp_ready0", 64'(in_ready), 1);
        tick();
        drive(1'b1, 3'b001, 1'b0, 8'h20, 8'h02);
        #1; chk("bp_ready1", 64'(in_ready), 1);
        tick();
        chk("bp_valid0", 64'(out_valid), 1);
        chk("bp_result0", 64'(result), 8'h11);
        drive(1'b1, 3'b010, 1'b0, 8'h33, 8'h00);
        #1; chk("bp_full", 64'(in_ready), 0);
        tick();
        chk("bp_stall_valid", 64'(out_valid), 1);
        chk("bp_stall_result", 64'(result), 8'h11);
        chk("bp_still_full", 64'(in_ready), 0);
        tick();
        chk("bp_stall_result2", 64'(result), 8'h11);
        out_ready = 1'b1;
        #1; chk("bp_ready_release", 64'(in_ready), 1);
        tick();
        drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        chk("bp_valid1", 64'(out_valid), 1);
        chk("bp_result1", 64'(result), 8'h22);
        tick();
        chk("bp_valid2", 64'(out_valid), 1);
        chk("bp_result2", 64'(result), 8'h33);
        tick();
        chk("bp_drain", 64'(out_valid), 0);

        // chain, back-to-back after an acc clear
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, chain_op[i], (i != 0), chain_x[i], (i == 0) ? 8'h00 : 8'hC3);
            tick();
            if (i >= 1) chk($sformatf("chain_result_%0d", i - 1), 64'(result), 64'(chain_exp[i - 1]));
        end
        drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        tick();
        chk("chain_result_3", 64'(result), 8'hF8);
        tick();

        // boundaries: NAND all ones, NOT zero
        drive(1'b1, 3'b100, 1'b0, 8'hFF, 8'hFF);
        tick();
        drive(1'b1, 3'b011, 1'b0, 8'h00, 8'h5A);
        tick();
        drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        chk("nand_result", 64'(result), 8'h00);
        chk("nand_zero", 64'(zero), 1);
        chk("nand_ones", 64'(ones), 0);
        chk("nand_parity", 64'(parity), 0);
        tick();
        chk("not_result", 64'(result), 8'hFF);
        chk("not_ones", 64'(ones), 8);
        chk("not_parity", 64'(parity), 0);
        chk("not_zero", 64'(zero), 0);
        tick();

        // acc_clr coinciding with a chained S2 load
        drive(1'b1, 3'b001, 1'b0, 8'h0F, 8'h00);
        tick();
        drive(1'b1, 3'b010, 1'b1, 8'hF0, 8'h00);
        tick();
        chk("clr_r0", 64'(result), 8'h0F);
        drive(1'b1, 3'b001, 1'b1, 8'h01, 8'hFF);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        chk("clr_uses_old_acc", 64'(result), 8'hFF);
        tick();
        chk("clr_next_sees_zero", 64'(result), 8'h01);
        tick();

        // reset with two requests in flight
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 1'b0, 8'h5A, 8'h00);
        tick();
        drive(1'b1, 3'b111, 1'b0, 8'h77, 8'h00);
        tick();
        chk("mid_full_valid", 64'(out_valid), 1);
        drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid_out_valid", 64'(out_valid), 0);
        chk("mid_result", 64'(result), 0);
        chk("mid_in_ready", 64'(in_ready), 1);
        tick();
        chk("mid_no_stale1", 64'(out_valid), 0);
        tick();
        chk("mid_no_stale2", 64'(out_valid), 0);
        drive(1'b1, 3'b001, 1'b1, 8'h00, 8'hFF);
        tick();
        drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        tick();
        chk("mid_acc_valid", 64'(out_valid), 1);
        chk("mid_acc_zero_result", 64'(result), 0);
        chk("mid_acc_zero_flag", 64'(zero), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
